uart_tx_fifo: RTL and testbench

//  Byte FIFO between the CPU IO write path and the UART transmitter.

---
 rtl/uart_tx_fifo.sv | 101 ++++++++++
 tb/tb_uart_tx_fifo.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the CPU IO write path and the UART transmitter.
// Latency: a byte pushed at edge N is visible on tx_valid/tx_data right after edge N (first-word fall-through).
// Backpressure: wr_ready=0 when full (extra pushes are dropped); pops only when tx_valid & tx_ready.
//
// Ports:
//   clk, resetn           clock, asynchronous active-low reset
//   wr_valid/wr_data      push strobe and byte; wr_ready = not full
//   flush                 synchronous clear of all entries (overrides push/pop)
//   tx_data/tx_valid      head byte and non-empty flag to the UART
//   tx_ready              UART ready; pop on tx_valid & tx_ready
//   level                 occupancy 0..DEPTH
//   ovf/ovf_clr           sticky overflow flag and its clear (only with UART_FIFO_OVF_EN)
//
// Build option: define UART_FIFO_OVF_EN to add the sticky overflow flag.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wr_valid,
  input  logic [7:0]    wr_data,
  output logic          wr_ready,
  input  logic          flush,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
`ifdef UART_FIFO_OVF_EN
  output logic          ovf,
  input  logic          ovf_clr,
`endif
  output logic [AW:0]   level
);

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full     = (level == LVL_FULL);
  assign empty    = (level == '0);
  // Push qualification uses the registered full flag only, so a pop in the
  // same cycle never makes room for a push into a full FIFO.
  assign push     = wr_valid & ~full;
  assign pop      = tx_valid & tx_ready;

  assign wr_ready = ~full;
  assign tx_valid = ~empty;
  assign tx_data  = mem[rd_ptr];

  // Storage is deliberately not reset; the head byte is don't-care while empty.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end
    end
  end

`ifdef UART_FIFO_OVF_EN
  // A push attempt while full sets the flag; setting takes priority over
  // any clear source in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovf <= 1'b0;
    end else if (wr_valid && full) begin
      ovf <= 1'b1;
    end else if (ovf_clr || flush) begin
      ovf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  logic       clk;
  logic       resetn;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       flush;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [4:0] level;
`ifdef UART_FIFO_OVF_EN
  logic       ovf;
  logic       ovf_clr;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] q[$];

  uart_tx_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .flush    (flush),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
`ifdef UART_FIFO_OVF_EN
    .ovf      (ovf),
    .ovf_clr  (ovf_clr),
`endif
    .level    (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one active edge; inputs are changed and outputs sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    step();
    wr_valid = 1'b0;
  endtask

  initial begin
    resetn   = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    flush    = 1'b0;
    tx_ready = 1'b0;
`ifdef UART_FIFO_OVF_EN
    ovf_clr  = 1'b0;
`endif

    // 1: reset state held for 3 cycles
    #2;
    for (int i = 0; i < 3; i++) begin
      chk("rst_level", level, 0);
      chk("rst_txv", tx_valid, 0);
      chk("rst_wrr", wr_ready, 1);
      step();
    end
    resetn = 1'b1;
    step();
    chk("post_rst_level", level, 0);

    // 2: two bytes, then drain
    push_byte(8'h48);
    chk("t2_lat_txv", tx_valid, 1);
    chk("t2_lat_dat", tx_data, 8'h48);
    push_byte(8'h69);
    chk("t2_level", level, 2);
    chk("t2_head", tx_data, 8'h48);
    tx_ready = 1'b1;
    step();
    chk("t2_pop1_dat", tx_data, 8'h69);
    chk("t2_pop1_lvl", level, 1);
    step();
    chk("t2_empty_lvl", level, 0);
    chk("t2_empty_txv", tx_valid, 0);
    tx_ready = 1'b0;

    // 3: fill, overflow drop, drain in order
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    chk("t3_full_lvl", level, 16);
    chk("t3_full_wrr", wr_ready, 0);
    // full + pop in the same cycle: the push must still be dropped
    wr_valid = 1'b1;
    wr_data  = 8'hAA;
    tx_ready = 1'b1;
    step();
    wr_valid = 1'b0;
    chk("t3_drop_pop_lvl", level, 15);
    tx_ready = 1'b0;
    chk("t3_drop_head", tx_data, 8'h01);
    push_byte(8'h10);
    push_byte(8'hAA);
    chk("t3_drop_lvl", level, 16);
    tx_ready = 1'b1;
    for (int i = 1; i < 17; i++) begin
      chk($sformatf("t3_drain%0d", i), tx_data, i);
      step();
    end
    tx_ready = 1'b0;
    chk("t3_drained", level, 0);
    chk("t3_drained_txv", tx_valid, 0);

    // 4: steady push+pop at level 15 across pointer wraps
    q.delete();
    for (int i = 0; i < 15; i++) begin
      push_byte(8'h30 + 8'(i));
      q.push_back(8'h30 + 8'(i));
    end
    chk("t4_lvl15", level, 15);
    wr_valid = 1'b1;
    tx_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wr_data = 8'h80 + 8'(i);
      chk($sformatf("t4_dat%0d", i), tx_data, q[0]);
      void'(q.pop_front());
      q.push_back(wr_data);
      step();
      chk($sformatf("t4_lvl%0d", i), level, 15);
    end
    wr_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("t4_tail%0d", i), tx_data, q[0]);
      void'(q.pop_front());
      step();
    end
    tx_ready = 1'b0;
    chk("t4_end_lvl", level, 0);

    // 5: flush overrides push and pop
    for (int i = 0; i < 5; i++) push_byte(8'hC0 + 8'(i));
    chk("t5_lvl5", level, 5);
    flush    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'hEE;
    tx_ready = 1'b1;
    step();
    flush    = 1'b0;
    wr_valid = 1'b0;
    tx_ready = 1'b0;
    chk("t5_lvl", level, 0);
    chk("t5_txv", tx_valid, 0);
    chk("t5_wrr", wr_ready, 1);
    push_byte(8'h5A);
    chk("t5_after_dat", tx_data, 8'h5A);

    // async reset mid-transfer empties immediately
    push_byte(8'h5B);
    tx_ready = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_txv", tx_valid, 0);
    chk("arst_lvl", level, 0);
    tx_ready = 1'b0;
    step();
    resetn = 1'b1;
    step();

`ifdef UART_FIFO_OVF_EN
    // 6: sticky overflow flag
    chk("t6_ovf_init", ovf, 0);
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    chk("t6_ovf_full", ovf, 0);
    push_byte(8'h55);
    chk("t6_ovf_set", ovf, 1);
    step();
    chk("t6_ovf_sticky", ovf, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("t6_ovf_clr", ovf, 0);
    wr_valid = 1'b1;
    wr_data  = 8'h55;
    ovf_clr  = 1'b1;
    step();
    wr_valid = 1'b0;
    ovf_clr  = 1'b0;
    chk("t6_set_wins", ovf, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t6_flush_clr", ovf, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
